ibex_instr_bus_responder: RTL



---
 rtl/ibex_instr_bus_responder_pkg.sv | 15 +
 rtl/ibex_instr_bus_responder_resp_pipe.sv | 80 ++++++++
 rtl/ibex_instr_bus_responder.sv | 99 +++++++++
 3 files changed

// File: rtl/ibex_instr_bus_responder_pkg.sv
// Shared types and helpers for the instruction-bus responder slice.
package ibex_instr_bus_responder_pkg;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } instr_resp_t;

  // Word-address width of the SRAM window; clamped to 1 so a one-word window still has a port.
  function automatic int unsigned instr_addr_width(input int unsigned mem_size_bytes);
    return (mem_size_bytes > 4) ? $clog2(mem_size_bytes / 4) : 1;
  endfunction

endpackage

// File: rtl/ibex_instr_bus_responder_resp_pipe.sv
// Fixed-latency delay line for fetch responses: {valid, err} from the grant cycle,
// data joining one cycle later straight from the SRAM read port.
module ibex_instr_resp_pipe
  import ibex_instr_bus_responder_pkg::*;
#(
  parameter int unsigned LATENCY  = 1,
  parameter bit          ResetAll = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  logic        err_i,
  input  logic [31:0] rdata_i,
  output instr_resp_t resp_o
);

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [LATENCY-1:0] err_q, err_d;
  logic [31:0]        rdata_out;

  always_comb begin
    valid_d    = '0;
    err_d      = '0;
    valid_d[0] = valid_i;
    err_d[0]   = err_i;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      err_d[i]   = err_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      err_q   <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Data stage k lines up with valid stage k+1, since SRAM data lags the grant by one cycle.
  if (LATENCY > 1) begin : g_data
    localparam int unsigned DS = LATENCY - 1;
    logic [DS-1:0][31:0] data_q, data_d;

    always_comb begin
      data_d    = '0;
      data_d[0] = rdata_i;
      for (int unsigned i = 1; i < DS; i++) begin
        data_d[i] = data_q[i-1];
      end
    end

    if (ResetAll) begin : g_rst
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) data_q <= '0;
        else         data_q <= data_d;
      end
    end else begin : g_norst
      always_ff @(posedge clk_i) begin
        data_q <= data_d;
      end
    end

    assign rdata_out = data_q[DS-1];
  end else begin : g_nodata
    assign rdata_out = rdata_i;
  end

  always_comb begin
    resp_o = '0;
    if (valid_q[LATENCY-1]) begin
      resp_o.valid = 1'b1;
      resp_o.err   = err_q[LATENCY-1];
      resp_o.rdata = err_q[LATENCY-1] ? '0 : rdata_out;
    end
  end

endmodule

// File: rtl/ibex_instr_bus_responder.sv
// Instruction-fetch bus slave: grant throttling, SRAM window decode and
// in-order fixed-latency responses with bus errors for out-of-window fetches.
module ibex_instr_bus_responder
  import ibex_instr_bus_responder_pkg::*;
#(
  parameter int unsigned NUM_OUTSTANDING = 2,
  parameter int unsigned LATENCY         = 1,
  parameter logic [31:0] MemBase         = 32'h0000_0000,
  parameter logic [31:0] MemSizeBytes    = 32'h0001_0000,
  parameter bit          ResetAll        = 1'b0,
  localparam int unsigned AW             = instr_addr_width(MemSizeBytes)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          stall_i,
  input  logic          instr_req_i,
  output logic          instr_gnt_o,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  output logic          instr_err_o,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic [31:0]   mem_rdata_i
);

  localparam int unsigned CW = $clog2(NUM_OUTSTANDING + 1);

  if (LATENCY < 1) begin : g_lat_chk
    $error("LATENCY must be >= 1");
  end
  if ((MemSizeBytes < 32'd4) || ((MemSizeBytes & (MemSizeBytes - 32'd1)) != 32'd0)) begin : g_size_chk
    $error("MemSizeBytes must be a power of 2 and >= 4");
  end
  if (NUM_OUTSTANDING < 1) begin : g_out_chk
    $error("NUM_OUTSTANDING must be >= 1");
  end

  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          grant;
  logic          in_range;
  logic [32:0]   addr_ext, lo_ext, hi_ext;
  instr_resp_t   resp;

  // 33-bit compare so a window ending at the top of the address space cannot wrap.
  assign addr_ext = {1'b0, instr_addr_i};
  assign lo_ext   = {1'b0, MemBase};
  assign hi_ext   = {1'b0, MemBase} + {1'b0, MemSizeBytes};
  assign in_range = (addr_ext >= lo_ext) && (addr_ext < hi_ext);

  assign instr_gnt_o = instr_req_i & ~stall_i & (out_cnt_q < CW'(NUM_OUTSTANDING));
  assign grant       = instr_req_i & instr_gnt_o;

  always_comb begin
    mem_req_o  = grant & in_range;
    mem_addr_o = '0;
    if (mem_req_o) begin
      mem_addr_o = AW'((instr_addr_i - MemBase) >> 2);
    end
  end

  ibex_instr_resp_pipe #(
    .LATENCY  (LATENCY),
    .ResetAll (ResetAll)
  ) u_resp_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (grant),
    .err_i   (~in_range),
    .rdata_i (mem_rdata_i),
    .resp_o  (resp)
  );

  assign instr_rvalid_o = resp.valid;
  assign instr_err_o    = resp.err;
  assign instr_rdata_o  = resp.rdata;

  always_comb begin
    out_cnt_d = out_cnt_q;
    case ({grant, resp.valid})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) out_cnt_q <= '0;
    else         out_cnt_q <= out_cnt_d;
  end

  a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_cnt_q <= CW'(NUM_OUTSTANDING));
  a_cnt_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_cnt_q == '0 && !grant) |=> (out_cnt_q == '0));
  a_rvalid_has_cnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_o |-> (out_cnt_q != '0));

endmodule
